// File: rtl/fir_input_deserializer_if.sv
// Sample-in / block-out bus of the FIR input deserializer.
// The serial side carries one sample per cycle plus a flush request; the
// block side carries four lanes, the emit strobe and status.
interface fir_input_deserializer_if #(
   parameter int NB_DATA_IN = 8,
   parameter int N_PARAL    = 4,
   parameter int NB_SEL     = $clog2(N_PARAL),
   parameter int NB_CNT     = 16
);
   logic                  i_valid;
   logic [NB_DATA_IN-1:0] i_data;
   logic                  i_flush;
   logic [NB_DATA_IN-1:0] o_data_0;
   logic [NB_DATA_IN-1:0] o_data_1;
   logic [NB_DATA_IN-1:0] o_data_2;
   logic [NB_DATA_IN-1:0] o_data_3;
   logic                  o_valid;
   logic [NB_SEL-1:0]     o_fill;
   logic [NB_CNT-1:0]     o_block_cnt;
   logic                  o_padded;

   // Producer of samples / consumer of blocks
   modport master (
      output i_valid, i_data, i_flush,
      input  o_data_0, o_data_1, o_data_2, o_data_3,
      input  o_valid, o_fill, o_block_cnt, o_padded
   );

   // The deserializer itself
   modport slave (
      input  i_valid, i_data, i_flush,
      output o_data_0, o_data_1, o_data_2, o_data_3,
      output o_valid, o_fill, o_block_cnt, o_padded
   );
endinterface

// File: rtl/fir_input_deserializer.sv
// Serial-to-parallel front end for the 4-lane unfolded FIR.
// Packs consecutive samples into lanes 0..N_PARAL-1 (lane 0 oldest) and
// presents each block on registered outputs held until the next emit, so the
// slow-clock domain can sample them at any point of its period. A flush emits
// the pending partial block with the unfilled lanes zeroed.
module fir_input_deserializer #(
   parameter int NB_DATA_IN = 8,
   parameter int N_PARAL    = 4,
   parameter int NB_SEL     = $clog2(N_PARAL),
   parameter int NB_CNT     = 16
) (
   input  logic                   clock_4,
   input  logic                   i_reset,
   input  logic                   i_enable,
   fir_input_deserializer_if.slave bus
);

   localparam logic [NB_SEL-1:0] LAST_SEL = NB_SEL'(N_PARAL - 1);

   logic [NB_SEL-1:0]                      sel_q, sel_d;
   logic [N_PARAL-2:0][NB_DATA_IN-1:0]     shadow_q, shadow_d;
   logic [N_PARAL-1:0][NB_DATA_IN-1:0]     lane_q, lane_d;
   logic [N_PARAL-1:0][NB_DATA_IN-1:0]     blk;
   logic [NB_CNT-1:0]                      cnt_q, cnt_d;
   logic                                   valid_q, valid_d;
   logic                                   padded_q, padded_d;

   logic accept;
   logic flush;
   logic full;
   logic emit;

   // Enable gates both requests, so a disabled cycle can never emit
   assign accept = i_enable & bus.i_valid;
   assign flush  = i_enable & bus.i_flush;
   assign full   = accept & (sel_q == LAST_SEL);
   assign emit   = full | (flush & ((sel_q != '0) | accept));

   // Block being emitted: filled lanes from the shadow, the current sample in
   // lane sel, zero above. On a full block this is simply shadow + sample.
   for (genvar k = 0; k < N_PARAL; k++) begin : g_lane
      if (k < N_PARAL - 1) begin : g_shadowed
         // Lane k below the fill point comes from the shadow register
         always_comb begin
            blk[k] = '0;
            if (NB_SEL'(k) < sel_q)
               blk[k] = shadow_q[k];
            else if ((NB_SEL'(k) == sel_q) && accept)
               blk[k] = bus.i_data;
         end
      end else begin : g_top
         // Top lane is only ever filled by the sample that completes the block
         always_comb begin
            blk[k] = '0;
            if ((NB_SEL'(k) == sel_q) && accept)
               blk[k] = bus.i_data;
         end
      end
   end

   // Next-state for fill counter, shadow lanes, outputs and block counter
   always_comb begin
      sel_d    = sel_q;
      shadow_d = shadow_q;
      lane_d   = lane_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      padded_d = padded_q;
      if (emit) begin
         sel_d    = '0;
         lane_d   = blk;
         cnt_d    = cnt_q + 1'b1;
         valid_d  = 1'b1;
         padded_d = ~full;
      end else if (accept) begin
         sel_d = sel_q + 1'b1;
         for (int k = 0; k < N_PARAL - 1; k++)
            if (sel_q == NB_SEL'(k))
               shadow_d[k] = bus.i_data;
      end
   end

   // State registers; synchronous active-low reset drops any partial block
   always_ff @(posedge clock_4) begin
      if (!i_reset) begin
         sel_q    <= '0;
         shadow_q <= '0;
         lane_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         padded_q <= 1'b0;
      end else begin
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         lane_q   <= lane_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         padded_q <= padded_d;
      end
   end

   assign bus.o_data_0    = lane_q[0];
   assign bus.o_data_1    = lane_q[1];
   assign bus.o_data_2    = lane_q[2];
   assign bus.o_data_3    = lane_q[3];
   assign bus.o_valid     = valid_q;
   assign bus.o_fill      = sel_q;
   assign bus.o_block_cnt = cnt_q;
   assign bus.o_padded    = padded_q;

endmodule

// File: tb/tb_fir_input_deserializer.sv
// Bench for fir_input_deserializer: directed scenarios then random traffic,
// scored against a sample-queue model. Two instances run side by side, one
// with a 2-bit block counter to exercise wrap-around.
module tb_fir_input_deserializer;

   logic clock_4 = 1'b0;
   logic i_reset;
   logic i_enable;

   always #5 clock_4 = ~clock_4;

   fir_input_deserializer_if #(.NB_CNT(16)) ifa ();
   fir_input_deserializer_if #(.NB_CNT(2))  ifb ();

   fir_input_deserializer #(.NB_CNT(16)) dut_a (
      .clock_4 (clock_4),
      .i_reset (i_reset),
      .i_enable(i_enable),
      .bus     (ifa.slave)
   );

   fir_input_deserializer #(.NB_CNT(2)) dut_b (
      .clock_4 (clock_4),
      .i_reset (i_reset),
      .i_enable(i_enable),
      .bus     (ifb.slave)
   );

   typedef struct packed {
      logic [3:0][7:0] lanes;
      logic            pad;
      logic [31:0]     cnt;
   } blk_t;

   blk_t       exq[$];
   logic [7:0] pend[$];

   logic [3:0][7:0] m_lanes;
   logic            m_pad;
   int unsigned     m_cnt;
   int unsigned     m_fill;

   int n_chk  = 0;
   int n_fail = 0;
   bit started = 1'b0;
   bit done    = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: collect accepted samples; four of them make a block, a flush
   // zero-pads whatever is pending.
   task automatic model_emit(input bit pad);
      blk_t b;
      for (int k = 0; k < 4; k++)
         b.lanes[k] = (k < pend.size()) ? pend[k] : 8'h00;
      m_cnt++;
      b.pad = pad;
      b.cnt = m_cnt;
      m_lanes = b.lanes;
      m_pad   = pad;
      pend.delete();
      exq.push_back(b);
   endtask

   task automatic model_step(input bit rst, input bit en, input bit v,
                             input logic [7:0] d, input bit fl);
      if (!rst) begin
         pend.delete();
         m_lanes = '0;
         m_pad   = 1'b0;
         m_cnt   = 0;
      end else if (en) begin
         if (v) pend.push_back(d);
         if (pend.size() == 4)
            model_emit(1'b0);
         else if (fl && pend.size() != 0)
            model_emit(1'b1);
      end
      m_fill = pend.size();
   endtask

   // One clock of stimulus: inputs change on the falling edge
   task automatic drive(input bit rst, input bit en, input bit v,
                        input logic [7:0] d, input bit fl);
      @(negedge clock_4);
      i_reset  = rst;
      i_enable = en;
      ifa.i_valid = v;  ifa.i_data = d;  ifa.i_flush = fl;
      ifb.i_valid = v;  ifb.i_data = d;  ifb.i_flush = fl;
      started = 1'b1;
      model_step(rst, en, v, d, fl);
   endtask

   task automatic smp(input logic [7:0] d);
      drive(1'b1, 1'b1, 1'b1, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
   endtask

   // Monitor: just after each rising edge, check strobe against the scoreboard
   // and every held output against the model state.
   initial begin
      blk_t e;
      bit   expv;
      forever begin
         @(posedge clock_4);
         #1;
         if (started && !done) begin
            expv = (exq.size() != 0);
            chk("valid_a", {31'b0, ifa.o_valid}, {31'b0, expv});
            chk("valid_b", {31'b0, ifb.o_valid}, {31'b0, expv});
            if (expv) begin
               e = exq.pop_front();
               chk("blk_lane0", {24'b0, ifa.o_data_0}, {24'b0, e.lanes[0]});
               chk("blk_lane1", {24'b0, ifa.o_data_1}, {24'b0, e.lanes[1]});
               chk("blk_lane2", {24'b0, ifa.o_data_2}, {24'b0, e.lanes[2]});
               chk("blk_lane3", {24'b0, ifa.o_data_3}, {24'b0, e.lanes[3]});
               chk("blk_padded", {31'b0, ifa.o_padded}, {31'b0, e.pad});
               chk("blk_cnt", {16'b0, ifa.o_block_cnt}, e.cnt & 32'hFFFF);
               chk("blk_cnt_wrap", {30'b0, ifb.o_block_cnt}, e.cnt & 32'h3);
            end
            chk("hold_data_a", {ifa.o_data_3, ifa.o_data_2, ifa.o_data_1, ifa.o_data_0}, m_lanes);
            chk("hold_data_b", {ifb.o_data_3, ifb.o_data_2, ifb.o_data_1, ifb.o_data_0}, m_lanes);
            chk("padded_a", {31'b0, ifa.o_padded}, {31'b0, m_pad});
            chk("fill_a", {30'b0, ifa.o_fill}, m_fill);
            chk("fill_b", {30'b0, ifb.o_fill}, m_fill);
            chk("cnt_a", {16'b0, ifa.o_block_cnt}, m_cnt & 32'hFFFF);
            chk("cnt_b", {30'b0, ifb.o_block_cnt}, m_cnt & 32'h3);
         end
      end
   end

   initial begin
      i_reset = 1'b0;  i_enable = 1'b0;
      ifa.i_valid = 1'b0;  ifa.i_data = '0;  ifa.i_flush = 1'b0;
      ifb.i_valid = 1'b0;  ifb.i_data = '0;  ifb.i_flush = 1'b0;

      // Reset held with traffic present
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);

      // Continuous ramp: three blocks
      for (int i = 0; i < 12; i++) smp(8'(i));
      idle(2);

      // Gapped samples with a disabled cycle carrying 99
      smp(8'hFF);  idle(2);
      smp(8'h80);  idle(2);
      drive(1'b1, 1'b0, 1'b1, 8'd99, 1'b0);
      smp(8'h7F);  idle(2);
      smp(8'h05);  idle(2);

      // Flush: partial, sample-with-flush at sel 0, empty flush
      smp(8'd10);  smp(8'd20);
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 8'd30, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
      // Flush arriving with the fourth sample is a normal block
      smp(8'd40);  smp(8'd41);  smp(8'd42);
      drive(1'b1, 1'b1, 1'b1, 8'd43, 1'b1);
      idle(1);

      // Reset mid-block discards the partial samples
      smp(8'd1);  smp(8'd2);  smp(8'd3);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      smp(8'd4);  smp(8'd5);  smp(8'd6);  smp(8'd7);
      idle(2);

      // Random traffic; plenty of blocks for the 2-bit counter to wrap
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 3) != 0),
               8'($urandom),
               ($urandom_range(0, 9) == 0));
      idle(3);

      @(negedge clock_4);
      done = 1'b1;
      chk("scoreboard_drained", exq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_input_deserializer.md
# fir_input_deserializer

Serial-to-parallel front end for the 4-lane parallel/unfolded FIR. Accepts one signed sample per `clock_4` cycle, packs four consecutive samples into lanes 0..3 with lane 0 the oldest, and presents the block on registered outputs with a one-cycle `o_valid` strobe. The outputs stay stable until the next block completes, so the FIR's slow-clock domain can sample them. A flush input pads a partial block with zeros.

## Interface
- `NB_DATA_IN`, 8, sample width (signed, two's complement)
- `N_PARAL`, 4, lanes per block (fixed at 4 for this block)
- `NB_SEL`, `$clog2(N_PARAL)`, fill-counter width
- `NB_CNT`, 16, block counter width
- `clock_4`  in  1  fast (4x) clock; all logic on its rising edge
- `i_reset`  in  1  synchronous, active-low reset
- `i_enable`  in  1  global enable; low freezes all state
- `i_valid`  in  1  `i_data` holds a sample this cycle
- `i_data`  in  NB_DATA_IN  serial input sample
- `i_flush`  in  1  emit the partial block now, zero-padded
- `o_data_0`..`o_data_3`  out  NB_DATA_IN each  packed lanes, lane 0 oldest
- `o_valid`  out  1  one-cycle strobe, new block on `o_data_*`
- `o_fill`  out  NB_SEL  number of samples in the pending (unemitted) block
- `o_block_cnt`  out  NB_CNT  blocks emitted since reset, wraps
- `o_padded`  out  1  last emitted block was produced by a flush

## Operation
- **State**
  - `sel`: fill counter 0..3.
  - `shadow[0..2]`: pending lanes.
  - Output registers: `o_data_*`, `o_padded`.
- **Accept.** On `i_enable & i_valid`, write `i_data` to lane `sel`.
- **Normal emit.** When `sel == 3` and a sample is accepted:
  - Output registers load `{shadow0, shadow1, shadow2, i_data}`.
  - `o_valid` goes to 1; `o_padded` goes to 0.
  - `sel` goes to 0; `o_block_cnt` increments.
- **Fill.** When a sample is accepted and `sel < 3`, `shadow[sel]` loads `i_data` and `sel` increments.
- **Flush.** On `i_enable & i_flush` with a pending partial block (`sel != 0`, or an accepted sample this cycle):
  - Lanes at or below the last filled index take the pending samples, including any sample accepted this cycle.
  - Higher lanes take 0.
  - Emit as above with `o_padded = 1`.
- **Flush with `sel == 3` and a valid sample** is a normal full block: `o_padded = 0`.
- **Flush with `sel == 0` and no valid sample** is a no-op: no `o_valid`, counter unchanged.
- **Enable low.** When `i_enable` is low:
  - `i_valid` and `i_flush` are ignored.
  - `o_valid` is forced to 0.
  - All other state holds.
- **Output hold.** `o_data_*` and `o_padded` change only on an emit. Lanes not re-emitted are never cleared except by reset.
- **Block counter.** `o_block_cnt` wraps from `2^NB_CNT-1` to 0.
- **No arithmetic on data.** Samples pass bit-exact.

## Timing
- **Reset (`i_reset = 0` at a rising edge):**
  - `o_data_*`, `o_valid`, `o_fill`, `o_block_cnt`, `o_padded`, `sel`, `shadow` all go to 0.
  - Reset has priority over enable, valid and flush.
  - A reset in mid-block discards the partial block and produces no emit.
- **Latency.** `o_valid` and the new `o_data_*` appear on the edge that accepts the 4th sample or the flush, one register stage. They are visible in the following cycle.
- **Continuous input** (`i_valid` high every cycle):
  - One `o_valid` every 4 `clock_4` cycles.
  - `o_data_*` stable for exactly 4 cycles, which is one slow-clock period.
- **Gapped input.** Gaps in `i_valid` stretch the block period; lane ordering is preserved.
- **`o_fill`** equals `sel` and is registered.

## Test plan
- **Reset.** Hold `i_reset = 0` for 3 cycles with `i_valid = 1`, `i_data = 8'h55` → all outputs 0, no `o_valid`.
- **Ramp.** Continuous samples 0,1,2,…,11 → `o_valid` on the cycles after samples 3, 7 and 11. Blocks (lane0..3) are {0,1,2,3}, {4,5,6,7}, {8,9,10,11}. `o_block_cnt` = 3, `o_padded` = 0.
- **Gapped input and enable.**
  - Send samples -1, -128, 127, 5 with `i_valid` gaps of 2 cycles, plus one `i_enable`-low cycle that carries a valid sample 99.
  - Required: the sample 99 is ignored.
  - Block is {8'hFF, 8'h80, 8'h7F, 8'h05}.
  - `o_valid` is exactly 1 cycle wide.
- **Flush.**
  - Send 10, 20, then `i_flush` alone → block {10, 20, 0, 0}, `o_padded` = 1.
  - Then `i_flush` with `i_valid` carrying 30 at `sel = 0` → {30, 0, 0, 0}.
  - Then `i_flush` with `sel = 0` and no valid → no `o_valid`.
- **Reset mid-block.** Send 1, 2, 3, assert reset for 1 cycle, then send 4, 5, 6, 7 → a single block {4, 5, 6, 7}. `o_block_cnt` = 1.
- **Counter wrap.** Use `NB_CNT = 2` and 5 full blocks → `o_block_cnt` sequence 1, 2, 3, 0, 1.
